fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end of the pipelined CPU. Owns the PC register, the IF/ID pipeline register and a small 2-bit branch history table (BHT).
- Each cycle it drives the instruction-memory address and decodes beq/bne for static target calculation.
- Steers the PC from the BHT prediction, from a stall request, or from an EX-stage redirect, and hands the fetched instruction to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_IDX_W, 4, BHT index width; BHT has 2**BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2].

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- imem_addr_o  out  32  instruction-memory address, equal to the current PC (combinational from the PC register).
- imem_data_i  in  32  instruction word, combinational read from instruction memory, valid in the same cycle.
- stall_i  in  1  hazard-unit load-use stall; holds the PC and IF/ID.
- redirect_i  in  1  EX-stage mispredict or jump; loads redirect_pc_i and flushes IF/ID.
- redirect_pc_i  in  32  corrected PC.
- bht_upd_i  in  1  EX-stage branch resolution strobe.
- bht_upd_pc_i  in  32  PC of the resolved branch.
- bht_taken_i  in  1  actual branch outcome.
- ifid_instr_o  out  32  registered instruction.
- ifid_pc4_o  out  32  registered PC+4 of that instruction.
- ifid_pred_taken_o  out  1  registered prediction for that instruction.
- ifid_valid_o  out  1  0 marks a bubble.

Behaviour:
- Reset (rst_i=1 at an edge):
  - PC <= RESET_PC.
  - ifid_instr_o, ifid_pc4_o and ifid_pred_taken_o <= 0; ifid_valid_o <= 0.
  - Every BHT entry <= 2'b01 (weakly not-taken).
  - Reset overrides every other input, including a pending redirect or update.
- Branch decode (combinational on imem_data_i):
  - A branch is opcode [31:26] = 6'b000100 (beq) or 6'b000101 (bne).
  - target = PC + 4 + ({{14{imm[15]}}, imm[15:0], 2'b00}), 32-bit wrap-around arithmetic, overflow ignored.
  - pred_taken = is_branch AND BHT[pc index][1].
- Next-PC priority at each non-reset edge:
  - 1. redirect_i=1: PC <= redirect_pc_i; IF/ID <= bubble (instr=0, pc4=0, pred=0, valid=0). Redirect beats stall_i.
  - 2. stall_i=1: PC and all IF/ID outputs hold their values.
  - 3. Otherwise: PC <= pred_taken ? target : PC+4; IF/ID <= {imem_data_i, PC+4, pred_taken, 1}.
- Latency:
  - An instruction at address A appears on the ifid_* outputs one edge after the PC equals A.
  - First valid IF/ID appears one edge after the edge where reset is released.
- BHT update:
  - On bht_upd_i=1, entry bht_upd_pc_i[BHT_IDX_W+1:2] increments (taken) or decrements (not taken), saturating at 3 and 0.
  - The update is independent of stall_i and redirect_i.
- Same-cycle lookup and update to one index: the lookup uses the pre-update value; the new value is visible from the next cycle.
- PC wrap: PC+4 from 32'hFFFF_FFFC wraps to 0; no exception is raised.
- Reset mid-stall or mid-redirect: reset state only; no residual held instruction.

Test Plan:
- Reset then free-run with imem returning 32'h0 (nop):
  - imem_addr_o sequence is 0, 4, 8, 12.
  - ifid_valid_o is 0 in the first cycle after reset, then 1 with ifid_pc4_o = 4, 8, 12.
- beq at PC 8, imm=3, BHT entry 2 at its reset value 01:
  - Predicted not taken; next PC = 12; ifid_pred_taken_o = 0.
  - Apply bht_upd_i twice with taken=1 for PC 8 (counter goes to 11).
  - Refetch at 8: next PC = 24 (8+4+12); ifid_pred_taken_o = 1.
- stall_i high for 3 cycles at PC 16:
  - imem_addr_o stays 16.
  - IF/ID holds the instruction from PC 12 (pc4=16), then resumes with PC 16's instruction.
- redirect_i with redirect_pc_i = 32'h40 while stall_i = 1:
  - Next PC = 0x40; ifid_valid_o = 0, ifid_instr_o = 0.
  - One edge later, IF/ID holds the word at 0x40 with pc4 = 0x44.
- Saturation:
  - Four taken updates on PC 4 leave the counter at 3; a fifth keeps it at 3.
  - Five not-taken updates leave it at 0.
  - A same-cycle lookup on PC 4 during the update uses the old value.
- rst_i asserted mid-run at PC 0x2C with a pending redirect:
  - Next PC = 0; ifid_valid_o = 0; all BHT entries read 01.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage port bundle: instruction memory, hazard/redirect
// controls, BHT update and the IF/ID register outputs.
interface fetch_stage_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        bht_upd_i;
  logic [31:0] bht_upd_pc_i;
  logic        bht_taken_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_pred_taken_o;
  logic        ifid_valid_o;

  modport master (
    output imem_addr_o,
    input  imem_data_i,
    input  stall_i,
    input  redirect_i,
    input  redirect_pc_i,
    input  bht_upd_i,
    input  bht_upd_pc_i,
    input  bht_taken_i,
    output ifid_instr_o,
    output ifid_pc4_o,
    output ifid_pred_taken_o,
    output ifid_valid_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_data_i,
    output stall_i,
    output redirect_i,
    output redirect_pc_i,
    output bht_upd_i,
    output bht_upd_pc_i,
    output bht_taken_i,
    input  ifid_instr_o,
    input  ifid_pc4_o,
    input  ifid_pred_taken_o,
    input  ifid_valid_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, 2-bit BHT predictor for beq/bne
// and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 4
) (
  input logic clk_i,
  input logic rst_i,
  fetch_stage_if.master bus
);

  localparam int BHT_N = 2 ** BHT_IDX_W;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        pred;
    logic        valid;
  } if_id_t;

  logic [31:0]          pc;
  logic [31:0]          pc4;
  logic [31:0]          offset;
  logic [31:0]          target;
  logic [5:0]           opcode;
  logic                 is_branch;
  logic                 pred_taken;
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] wr_idx;
  logic [1:0]           bht [BHT_N];
  logic [1:0]           ctr;
  logic [1:0]           ctr_next;
  if_id_t               ifid;
  logic                 unused;

  assign opcode    = bus.imem_data_i[31:26];
  assign is_branch = (opcode == 6'b000100)
                   | (opcode == 6'b000101);
  assign offset    = {{14{bus.imem_data_i[15]}},
                      bus.imem_data_i[15:0], 2'b00};
  assign pc4       = pc + 32'd4;
  assign target    = pc4 + offset;

  assign rd_idx     = pc[BHT_IDX_W+1:2];
  assign wr_idx     = bus.bht_upd_pc_i[BHT_IDX_W+1:2];
  assign pred_taken = is_branch & bht[rd_idx][1];

  assign unused = ^{bus.bht_upd_pc_i[31:BHT_IDX_W+2],
                    bus.bht_upd_pc_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc   <= RESET_PC;
      ifid <= '0;
    end else if (bus.redirect_i) begin
      pc   <= bus.redirect_pc_i;
      ifid <= '0;
    end else if (!bus.stall_i) begin
      pc   <= pred_taken ? target : pc4;
      ifid <= '{instr: bus.imem_data_i,
                pc4:   pc4,
                pred:  pred_taken,
                valid: 1'b1};
    end
  end

  // Saturating 2-bit counter step for the resolved branch
  assign ctr = bht[wr_idx];

  always_comb begin
    ctr_next = ctr;
    if (bus.bht_taken_i) begin
      if (ctr != 2'b11)
        ctr_next = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00)
        ctr_next = ctr - 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_N; i++)
        bht[i] <= 2'b01;
    end else if (bus.bht_upd_i) begin
      bht[wr_idx] <= ctr_next;
    end
  end

  assign bus.imem_addr_o       = pc;
  assign bus.ifid_instr_o      = ifid.instr;
  assign bus.ifid_pc4_o        = ifid.pc4;
  assign bus.ifid_pred_taken_o = ifid.pred;
  assign bus.ifid_valid_o      = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a cycle-level
// behavioural model of PC steering, IF/ID and predictor counters.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .BHT_IDX_W(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always_comb bus.imem_data_i = mem[bus.imem_addr_o[9:2]];

  int asserts = 0;
  int fails   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_pred;
  logic        m_valid;
  int          m_bht [16];

  function automatic logic [31:0] br_word(input logic ne,
                                          input logic [15:0] imm);
    return {5'b00010, ne, 10'd0, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic step(input logic r, input logic s, input logic rd,
                      input logic [31:0] rpc, input logic u,
                      input logic [31:0] upc, input logic t);
    logic [31:0] w;
    logic [31:0] tgt;
    bit          br;
    bit          p;
    int          k;
    int          j;
    @(negedge clk);
    rst               = r;
    bus.stall_i       = s;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    bus.bht_upd_i     = u;
    bus.bht_upd_pc_i  = upc;
    bus.bht_taken_i   = t;
    w   = mem[m_pc[9:2]];
    br  = (w[31:26] == 6'd4) || (w[31:26] == 6'd5);
    k   = int'((m_pc >> 2) % 16);
    p   = br && (m_bht[k] >= 2);
    tgt = m_pc + 32'd4 + 32'(int'($signed(w[15:0])) * 4);
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_pred = 0; m_valid = 0;
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
    end else begin
      if (rd) begin
        m_pc = rpc; m_instr = 0; m_pc4 = 0; m_pred = 0; m_valid = 0;
      end else if (!s) begin
        m_instr = w;
        m_pc4   = m_pc + 32'd4;
        m_pred  = p;
        m_valid = 1'b1;
        m_pc    = p ? tgt : m_pc + 32'd4;
      end
      if (u) begin
        j = int'((upc >> 2) % 16);
        if (t) m_bht[j] = (m_bht[j] == 3) ? 3 : m_bht[j] + 1;
        else   m_bht[j] = (m_bht[j] == 0) ? 0 : m_bht[j] - 1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input logic [31:0] a);
    step(0, 0, 1, a, 0, 0, 0);
  endtask

  task automatic test_reset();
    clear_mem();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    asserts++;
    if (bus.imem_addr_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_pc got %h want 0", bus.imem_addr_o);
    end
    asserts++;
    if (bus.ifid_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got %b want 0", bus.ifid_valid_o);
    end
    asserts++;
    if (bus.ifid_instr_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_instr got %h want 0", bus.ifid_instr_o);
    end
    asserts++;
    if (bus.ifid_pc4_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_pc4 got %h want 0", bus.ifid_pc4_o);
    end
    asserts++;
    if (bus.ifid_pred_taken_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_pred got %b want 0", bus.ifid_pred_taken_o);
    end
  endtask

  task automatic test_nop_run();
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      asserts++;
      if (bus.imem_addr_o !== 32'(4 * i)) begin
        fails++;
        $display("FAIL nop_addr got %h want %h",
                 bus.imem_addr_o, 32'(4 * i));
      end
      asserts++;
      if (bus.ifid_valid_o !== 1'b1 || bus.ifid_pc4_o !== 32'(4 * i)) begin
        fails++;
        $display("FAIL nop_ifid got v=%b pc4=%h want v=1 pc4=%h",
                 bus.ifid_valid_o, bus.ifid_pc4_o, 32'(4 * i));
      end
    end
  endtask

  task automatic test_branch_predict();
    clear_mem();
    mem[2] = br_word(1'b0, 16'd3);
    step(1, 0, 0, 0, 0, 0, 0);
    run(2);
    step(0, 0, 0, 0, 0, 0, 0);
    asserts++;
    if (bus.imem_addr_o !== 32'd12 || bus.ifid_pred_taken_o !== 1'b0) begin
      fails++;
      $display("FAIL beq_cold got pc=%h pred=%b want pc=c pred=0",
               bus.imem_addr_o, bus.ifid_pred_taken_o);
    end
    step(0, 1, 0, 0, 1, 32'd8, 1);
    step(0, 1, 0, 0, 1, 32'd8, 1);
    jump(32'd8);
    step(0, 0, 0, 0, 0, 0, 0);
    asserts++;
    if (bus.imem_addr_o !== 32'd24 || bus.ifid_pred_taken_o !== 1'b1) begin
      fails++;
      $display("FAIL beq_warm got pc=%h pred=%b want pc=18 pred=1",
               bus.imem_addr_o, bus.ifid_pred_taken_o);
    end
    asserts++;
    if (bus.ifid_pc4_o !== 32'd12 || bus.ifid_instr_o !== mem[2]) begin
      fails++;
      $display("FAIL beq_ifid got pc4=%h ins=%h want pc4=c ins=%h",
               bus.ifid_pc4_o, bus.ifid_instr_o, mem[2]);
    end
  endtask

  task automatic test_stall_redirect();
    clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = $urandom & 32'h03FF_FFFF;
    step(1, 0, 0, 0, 0, 0, 0);
    run(4);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      asserts++;
      if (bus.imem_addr_o !== 32'd16 || bus.ifid_pc4_o !== 32'd16 ||
          bus.ifid_instr_o !== mem[3]) begin
        fails++;
        $display("FAIL stall_hold got pc=%h pc4=%h ins=%h want 10/10/%h",
                 bus.imem_addr_o, bus.ifid_pc4_o, bus.ifid_instr_o, mem[3]);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    asserts++;
    if (bus.imem_addr_o !== 32'd20 || bus.ifid_pc4_o !== 32'd20 ||
        bus.ifid_instr_o !== mem[4]) begin
      fails++;
      $display("FAIL stall_resume got pc=%h pc4=%h ins=%h want 14/14/%h",
               bus.imem_addr_o, bus.ifid_pc4_o, bus.ifid_instr_o, mem[4]);
    end
    step(0, 1, 1, 32'h40, 0, 0, 0);
    asserts++;
    if (bus.imem_addr_o !== 32'h40 || bus.ifid_valid_o !== 1'b0 ||
        bus.ifid_instr_o !== 32'h0) begin
      fails++;
      $display("FAIL redirect got pc=%h v=%b ins=%h want 40/0/0",
               bus.imem_addr_o, bus.ifid_valid_o, bus.ifid_instr_o);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    asserts++;
    if (bus.ifid_pc4_o !== 32'h44 || bus.ifid_valid_o !== 1'b1 ||
        bus.ifid_instr_o !== mem[16]) begin
      fails++;
      $display("FAIL redirect_fetch got pc4=%h v=%b ins=%h want 44/1/%h",
               bus.ifid_pc4_o, bus.ifid_valid_o, bus.ifid_instr_o, mem[16]);
    end
  endtask

  task automatic test_saturation();
    clear_mem();
    mem[1] = br_word(1'b1, 16'd5);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 32'd4, 1);
    jump(32'd4);
    step(0, 0, 0, 0, 0, 0, 0);
    asserts++;
    if (bus.ifid_pred_taken_o !== 1'b1 || bus.imem_addr_o !== 32'd28) begin
      fails++;
      $display("FAIL sat_high got pred=%b pc=%h want 1/1c",
               bus.ifid_pred_taken_o, bus.imem_addr_o);
    end
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 32'd4, 0);
    step(0, 1, 0, 0, 1, 32'd4, 1);
    jump(32'd4);
    step(0, 0, 0, 0, 0, 0, 0);
    asserts++;
    if (bus.ifid_pred_taken_o !== 1'b0 || bus.imem_addr_o !== 32'd8) begin
      fails++;
      $display("FAIL sat_low got pred=%b pc=%h want 0/8",
               bus.ifid_pred_taken_o, bus.imem_addr_o);
    end
    jump(32'd4);
    step(0, 0, 0, 0, 1, 32'd4, 1);
    asserts++;
    if (bus.ifid_pred_taken_o !== 1'b0) begin
      fails++;
      $display("FAIL same_cycle_old got pred=%b want 0",
               bus.ifid_pred_taken_o);
    end
    jump(32'd4);
    step(0, 0, 0, 0, 0, 0, 0);
    asserts++;
    if (bus.ifid_pred_taken_o !== 1'b1) begin
      fails++;
      $display("FAIL same_cycle_new got pred=%b want 1",
               bus.ifid_pred_taken_o);
    end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = br_word(1'b0, 16'd2);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 1, 32'(4 * i), 1);
      step(0, 1, 0, 0, 1, 32'(4 * i), 1);
    end
    jump(32'h2C);
    step(1, 1, 1, 32'h80, 1, 32'h0, 1);
    asserts++;
    if (bus.imem_addr_o !== 32'h0 || bus.ifid_valid_o !== 1'b0 ||
        bus.ifid_instr_o !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset got pc=%h v=%b ins=%h want 0/0/0",
               bus.imem_addr_o, bus.ifid_valid_o, bus.ifid_instr_o);
    end
    for (int i = 0; i < 16; i++) begin
      jump(32'(4 * i));
      step(0, 0, 0, 0, 0, 0, 0);
      asserts++;
      if (bus.ifid_pred_taken_o !== 1'b0 ||
          bus.imem_addr_o !== 32'(4 * i + 4)) begin
        fails++;
        $display("FAIL bht_reset idx=%0d got pred=%b pc=%h want 0/%h",
                 i, bus.ifid_pred_taken_o, bus.imem_addr_o, 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[255] = 32'h1234_5678;
    jump(32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0, 0);
    asserts++;
    if (bus.imem_addr_o !== 32'h0 || bus.ifid_pc4_o !== 32'h0 ||
        bus.ifid_valid_o !== 1'b1) begin
      fails++;
      $display("FAIL pc_wrap got pc=%h pc4=%h v=%b want 0/0/1",
               bus.imem_addr_o, bus.ifid_pc4_o, bus.ifid_valid_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      if ($urandom_range(2) == 0) r = {5'b00010, r[26:0]};
      mem[i] = r;
    end
    step(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(99) == 0,
           $urandom_range(4) == 0,
           $urandom_range(7) == 0,
           $urandom & 32'h0000_03FC,
           $urandom_range(2) == 0,
           $urandom,
           1'($urandom));
      asserts++;
      if (bus.imem_addr_o !== m_pc || bus.ifid_instr_o !== m_instr ||
          bus.ifid_pc4_o !== m_pc4 || bus.ifid_pred_taken_o !== m_pred ||
          bus.ifid_valid_o !== m_valid) begin
        fails++;
        $display("FAIL rand c=%0d got %h %h %h %b %b want %h %h %h %b %b",
                 c, bus.imem_addr_o, bus.ifid_instr_o, bus.ifid_pc4_o,
                 bus.ifid_pred_taken_o, bus.ifid_valid_o,
                 m_pc, m_instr, m_pc4, m_pred, m_valid);
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.bht_upd_i     = 1'b0;
    bus.bht_upd_pc_i  = 32'h0;
    bus.bht_taken_i   = 1'b0;
    test_reset();
    test_nop_run();
    test_branch_predict();
    test_stall_redirect();
    test_saturation();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
